avm_pio_mirror: RTL
===================

Name: avm_pio_mirror

Overview:
- Avalon-MM initiator that polls the switch PIO and mirrors its value onto the LED PIO and the six HEX PIOs.
- Sits in the FPGA fabric as a second master on the lightweight PIO interconnect, alongside the HPS bridge.
- Provides an HPS-independent "switches to LEDs/7-seg" path for board bring-up and self-test.

Parameters:
- ADDR_W, 16, Avalon address width (byte addresses).
- SW_BASE, 16'h0010, switch PIO data register address.
- LED_BASE, 16'h0000, LED PIO data register address.
- HEX_BASE, 16'h0020, HEX0 PIO data register address.
- HEX_STRIDE, 16'h0010, address step between HEXn and HEXn+1.
- POLL_DIV, 50000, idle cycles between poll rounds (1 ms at 50 MHz); minimum 1.
- TIMEOUT_CYC, 255, maximum consecutive waitrequest cycles before a transfer is aborted.

Ports:
- clk_clk  in  1  system clock.
- reset_reset_n  in  1  asynchronous active-low reset.
- enable  in  1  when 1, poll rounds are started; sampled only in IDLE.
- avm_address  out  ADDR_W  byte address.
- avm_read  out  1  read request.
- avm_write  out  1  write request.
- avm_writedata  out  32  write data.
- avm_byteenable  out  4  fixed 4'hF.
- avm_readdata  in  32  read data, valid when avm_read && !avm_waitrequest.
- avm_waitrequest  in  1  interconnect stall.
- sw_value  out  10  last switch value read.
- busy  out  1  1 whenever the FSM is not IDLE.
- err  out  1  sticky timeout flag; cleared only by reset.

Behaviour:
- The clock and reset ports are clk_clk and reset_reset_n; there is one clock, and the reset is asynchronous and active-low.
- Reset values:
  - avm_read = avm_write = 0; avm_address = 0; avm_writedata = 0.
  - sw_value = 0; busy = 0; err = 0.
  - Poll counter = 0; state = IDLE.
- Reset asserted mid-transfer drops avm_read/avm_write immediately.
- FSM states:
  - IDLE: counter increments while enable = 1. When counter == POLL_DIV-1, clear it and go to RD_SW. When enable = 0, hold the counter at 0.
  - RD_SW: assert avm_read, address SW_BASE. On !avm_waitrequest, latch avm_readdata[9:0] into sw_value and go to WR_LED.
  - WR_LED: assert avm_write, address LED_BASE, writedata {22'b0, sw_value}. On !avm_waitrequest, go to WR_HEX with idx = 0.
  - WR_HEX: assert avm_write, address HEX_BASE + idx*HEX_STRIDE, writedata {25'b0, seg}. On !avm_waitrequest: if idx == 5, go to IDLE; otherwise idx += 1.
- Digit mapping for the HEX writes:
  - idx 0 → sw_value[3:0]; idx 1 → sw_value[7:4]; idx 2 → {2'b0, sw_value[9:8]}.
  - idx 3..5 → blank, seg = 7'h7F.
- Segment code is active-low {g,f,e,d,c,b,a}:
  - 0..7: 40, 79, 24, 30, 19, 12, 02, 78.
  - 8..F: 00, 10, 08, 03, 46, 21, 06, 0E.
- Avalon rules:
  - Address, data and command are held stable while waitrequest = 1.
  - Command drops the cycle after acceptance; a command is never asserted on the cycle immediately following acceptance, so there is one idle bus cycle between transfers.
  - Read and write are never asserted together.
  - A full round with zero waitrequest is 8 transfers in 16 cycles.
- Timeout:
  - A wait counter resets at each new transfer and increments on every cycle with waitrequest = 1.
  - When it reaches TIMEOUT_CYC: deassert the command, set err, return to IDLE. The remainder of the round is abandoned and sw_value is unchanged if the read timed out.
- enable deasserted mid-round: the round completes; no further rounds start.

Optional Feature:
- Macro: AVM_PIO_MIRROR_CHANGE_ONLY_EN.
- With the macro: after RD_SW, if the newly read value equals the previous sw_value and a valid flag is set, skip WR_LED/WR_HEX and return to IDLE. The valid flag sets after the first completed round and clears on reset or timeout.
- Without the macro: every round performs all 7 writes.

Decomposition:
- Package avm_pio_mirror_pkg holds:
  - state enum (IDLE, RD_SW, WR_LED, WR_HEX);
  - SEG_BLANK = 7'h7F;
  - NUM_HEX = 6;
  - the 16-entry segment constant table.
- Sub-module hex7seg_enc: combinational 4-bit to 7-bit active-low encoder, used once.

Test Plan:
- Reset, then enable = 1, POLL_DIV = 4, switches = 10'h2A5, no waitrequest:
  - Read at 0x0010.
  - Writes: 0x0000 ← 0x2A5; 0x0020 ← 0x12; 0x0030 ← 0x08; 0x0040 ← 0x24; 0x0050, 0x0060, 0x0070 ← 0x7F.
  - busy falls after the last write.
- Random waitrequest of 0–5 cycles on every transfer → same write sequence; address/data stable during stalls; no back-to-back commands.
- waitrequest stuck at 1 on the read, TIMEOUT_CYC = 8 → avm_read drops after 8 stall cycles; err = 1; sw_value keeps its old value; the next round proceeds normally once the stall is released.
- reset_reset_n pulsed low during WR_HEX idx 2 → all outputs return to reset values asynchronously; the first round after release starts POLL_DIV cycles later.
- With AVM_PIO_MIRROR_CHANGE_ONLY_EN and switches constant 10'h3FF over 3 rounds → round 1 has 7 writes; rounds 2–3 have the read only. Change switches to 10'h000 → round 4 writes LED 0x000 and HEX0–2 ← 0x40.
- enable dropped mid-round → the current round completes; no read is issued for 3×POLL_DIV cycles afterwards.

Source files
------------

// File: rtl/avm_pio_mirror_pkg.sv
// Shared FSM type, HEX count and active-low {g,f,e,d,c,b,a} segment table
// for the switch-to-LED/HEX Avalon mirror.
package avm_pio_mirror_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      RD_SW  = 2'd1,
      WR_LED = 2'd2,
      WR_HEX = 2'd3
   } state_t;

   localparam logic [6:0]  SEG_BLANK = 7'h7F;
   localparam int unsigned NUM_HEX   = 6;

   localparam logic [6:0] SEG_TABLE [16] = '{
      7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
      7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
   };

endpackage

// File: rtl/hex7seg_enc.sv
// Combinational 4-bit digit to 7-segment active-low encoder.
module hex7seg_enc
   import avm_pio_mirror_pkg::*;
(
   input  logic [3:0] digit,
   output logic [6:0] seg
);

   assign seg = SEG_TABLE[digit];

endmodule

// File: rtl/avm_pio_mirror.sv
// Avalon-MM initiator polling the switch PIO and mirroring it onto LED and HEX0-5 PIOs.
// Optional macro AVM_PIO_MIRROR_CHANGE_ONLY_EN skips the writes when the switches are unchanged.
module avm_pio_mirror
   import avm_pio_mirror_pkg::*;
#(
   parameter int unsigned       ADDR_W      = 16,
   parameter logic [ADDR_W-1:0] SW_BASE     = 16'h0010,
   parameter logic [ADDR_W-1:0] LED_BASE    = 16'h0000,
   parameter logic [ADDR_W-1:0] HEX_BASE    = 16'h0020,
   parameter logic [ADDR_W-1:0] HEX_STRIDE  = 16'h0010,
   parameter int unsigned       POLL_DIV    = 50000,
   parameter int unsigned       TIMEOUT_CYC = 255
)(
   input  logic              clk_clk,
   input  logic              reset_reset_n,
   input  logic              enable,
   output logic [ADDR_W-1:0] avm_address,
   output logic              avm_read,
   output logic              avm_write,
   output logic [31:0]       avm_writedata,
   output logic [3:0]        avm_byteenable,
   input  logic [31:0]       avm_readdata,
   input  logic              avm_waitrequest,
   output logic [9:0]        sw_value,
   output logic              busy,
   output logic              err
);

   localparam int unsigned PCNT_W = (POLL_DIV > 1) ? $clog2(POLL_DIV) : 1;
   localparam int unsigned WCNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [PCNT_W-1:0] POLL_LAST = PCNT_W'(POLL_DIV - 1);
   localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(TIMEOUT_CYC - 1);
   localparam logic [2:0]        HEX_LAST  = 3'(NUM_HEX - 1);

   state_t              state;
   logic [PCNT_W-1:0]   poll_cnt;
   logic [WCNT_W-1:0]   wait_cnt;
   logic [2:0]          idx;
   logic [3:0]          digit;
   logic [6:0]          enc_seg;
   logic [6:0]          hex_seg;
   logic [ADDR_W-1:0]   hex_addr;
   logic                cmd;
   logic                accept;
   logic                stall_expired;
   logic                round_done;
   logic                skip_writes;
   logic                unused_rd;

   assign avm_byteenable = 4'hF;
   assign busy           = (state != IDLE);
   assign unused_rd      = ^avm_readdata[31:10];

   assign cmd           = avm_read | avm_write;
   assign accept        = cmd && !avm_waitrequest;
   assign stall_expired = cmd && avm_waitrequest && (wait_cnt == WAIT_LAST);
   assign round_done    = (state == WR_HEX) && accept && (idx == HEX_LAST);

   always_comb begin
      digit = 4'h0;
      case (idx)
         3'd0:    digit = sw_value[3:0];
         3'd1:    digit = sw_value[7:4];
         3'd2:    digit = {2'b00, sw_value[9:8]};
         default: digit = 4'h0;
      endcase
   end

   hex7seg_enc u_enc (
      .digit (digit),
      .seg   (enc_seg)
   );

   assign hex_seg  = (idx < 3'd3) ? enc_seg : SEG_BLANK;
   assign hex_addr = HEX_BASE + HEX_STRIDE * ADDR_W'(idx);

`ifdef AVM_PIO_MIRROR_CHANGE_ONLY_EN
   logic sw_valid;

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n)
         sw_valid <= 1'b0;
      else if (stall_expired)
         sw_valid <= 1'b0;
      else if (round_done)
         sw_valid <= 1'b1;
   end

   assign skip_writes = sw_valid && (avm_readdata[9:0] == sw_value);
`else
   assign skip_writes = 1'b0;
`endif

   always_ff @(posedge clk_clk or negedge reset_reset_n) begin
      if (!reset_reset_n) begin
         state         <= IDLE;
         poll_cnt      <= '0;
         wait_cnt      <= '0;
         idx           <= '0;
         avm_read      <= 1'b0;
         avm_write     <= 1'b0;
         avm_address   <= '0;
         avm_writedata <= '0;
         sw_value      <= '0;
         err           <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (!enable) begin
                  poll_cnt <= '0;
               end else if (poll_cnt == POLL_LAST) begin
                  poll_cnt    <= '0;
                  state       <= RD_SW;
                  avm_read    <= 1'b1;
                  avm_address <= SW_BASE;
                  wait_cnt    <= '0;
               end else begin
                  poll_cnt <= poll_cnt + 1'b1;
               end
            end
            default: begin
               if (stall_expired) begin
                  avm_read  <= 1'b0;
                  avm_write <= 1'b0;
                  err       <= 1'b1;
                  state     <= IDLE;
               end else if (cmd && avm_waitrequest) begin
                  wait_cnt <= wait_cnt + 1'b1;
               end else if (accept) begin
                  avm_read  <= 1'b0;
                  avm_write <= 1'b0;
                  case (state)
                     RD_SW: begin
                        sw_value <= avm_readdata[9:0];
                        state    <= skip_writes ? IDLE : WR_LED;
                     end
                     WR_LED: begin
                        idx   <= '0;
                        state <= WR_HEX;
                     end
                     default: begin
                        if (idx == HEX_LAST)
                           state <= IDLE;
                        else
                           idx <= idx + 1'b1;
                     end
                  endcase
               end else begin
                  // Idle bus cycle after an acceptance: present the next command.
                  wait_cnt <= '0;
                  case (state)
                     WR_LED: begin
                        avm_write     <= 1'b1;
                        avm_address   <= LED_BASE;
                        avm_writedata <= {22'b0, sw_value};
                     end
                     WR_HEX: begin
                        avm_write     <= 1'b1;
                        avm_address   <= hex_addr;
                        avm_writedata <= {25'b0, hex_seg};
                     end
                     default: begin
                        avm_read    <= 1'b1;
                        avm_address <= SW_BASE;
                     end
                  endcase
               end
            end
         endcase
      end
   end

endmodule
